spi_slave: RTL and testbench

SPI slave-side endpoint: the responder for the SPI master already in the design. It sits between an external SPI master (SCLK/MOSI/SSbar in, MISO out) and an on-chip register or APB-facing client. It oversamples the SPI pins on the system clock, shifts one MSB-first word per frame in both directions, and hands the received word to the client with a one-cycle valid pulse.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 18 +
 rtl/spi_slave.sv | 96 +++++++++
 tb/tb_spi_slave.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI word size, mode encodings, MISO drive levels and slave FSM states
package spi_pkg;
  localparam int WORD_LENGTH = 8;
  localparam logic [1:0] MODE_POL_PHS_00 = 2'b00;
  localparam logic [1:0] MODE_POL_PHS_01 = 2'b01;
  localparam logic [1:0] MODE_POL_PHS_10 = 2'b10;
  localparam logic [1:0] MODE_POL_PHS_11 = 2'b11;
  localparam logic CONNECTED_FROM_SLAVE = 1'b1;
  localparam logic DISCONNECTED_FROM_SLAVE = 1'b0;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} slave_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer plus one delay stage yielding rise/fall pulses
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [2:0] r_sh;
  always_ff @(posedge clk) begin
    if (rst) r_sh <= '0;
    else r_sh <= {r_sh[1:0], i_async};
  end
  assign o_sync = r_sh[1];
  assign o_rise = r_sh[1] & ~r_sh[2];
  assign o_fall = ~r_sh[1] & r_sh[2];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave, MSB-first full-duplex word transfer with tx holding register
module spi_slave #(
  parameter int WORD_LENGTH = spi_pkg::WORD_LENGTH,
  parameter logic [1:0] SPI_MODE = spi_pkg::MODE_POL_PHS_00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SCLK,
  input  logic                   MOSI,
  input  logic                   SSbar,
  output logic                   MISO,
  output logic                   miso_oe,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic                   tx_load,
  output logic                   tx_ready,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_data_valid,
  output logic                   busy
);
  import spi_pkg::*;
  localparam int CW = $clog2(WORD_LENGTH);
  localparam logic CPOL = SPI_MODE[1];
  localparam logic CPHA = SPI_MODE[0];
  slave_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [WORD_LENGTH-1:0] r_hold, r_tx_sh, r_rx_sh, r_rx_data;
  logic [1:0] r_mosi_s;
  logic r_full, r_miso, r_rx_valid, r_sampled;
  logic w_sclk_sync, w_sclk_rise, w_sclk_fall, w_ss_sync, w_ss_rise, w_ss_fall;
  logic w_lead, w_trail, w_sample, w_shift, w_start;
  logic [WORD_LENGTH-1:0] w_word;
  spi_sync_edge u_sclk (.clk(clk), .rst(rst), .i_async(SCLK), .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_sync_edge u_ss (.clk(clk), .rst(rst), .i_async(SSbar), .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall(w_ss_fall));
  // the synced level after an edge tells whether it left or returned to the CPOL idle level
  assign w_lead = (w_sclk_rise | w_sclk_fall) & (w_sclk_sync != CPOL);
  assign w_trail = (w_sclk_rise | w_sclk_fall) & (w_sclk_sync == CPOL);
  assign w_sample = CPHA ? w_trail : w_lead;
  // CPHA=0 ignores the trailing edge that closes the previous word until this word has sampled
  assign w_shift = CPHA ? w_lead : (w_trail & r_sampled);
  assign w_start = (r_state == IDLE && w_ss_fall) || (r_state == DONE && !w_ss_sync);
  assign w_word = r_full ? r_hold : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= CW'(WORD_LENGTH - 1);
      r_hold <= '0;
      r_tx_sh <= '0;
      r_rx_sh <= '0;
      r_rx_data <= '0;
      r_mosi_s <= '0;
      r_full <= 1'b0;
      r_miso <= 1'b0;
      r_rx_valid <= 1'b0;
      r_sampled <= 1'b0;
    end else begin
      r_mosi_s <= {r_mosi_s[0], MOSI};
      r_rx_valid <= 1'b0;
      if (w_start) r_full <= 1'b0;
      else if (tx_load && !r_full) begin
        r_hold <= tx_data;
        r_full <= 1'b1;
      end
      if (w_start) begin
        r_state <= SHIFT;
        r_cnt <= CW'(WORD_LENGTH - 1);
        r_sampled <= 1'b0;
        r_tx_sh <= CPHA ? w_word : w_word << 1;
        r_miso <= CPHA ? 1'b0 : w_word[WORD_LENGTH-1];
      end else if (r_state == DONE || (r_state == SHIFT && w_ss_rise)) begin
        r_state <= IDLE;
        r_miso <= 1'b0;
      end else if (r_state == SHIFT) begin
        if (w_shift) begin
          r_miso <= r_tx_sh[WORD_LENGTH-1];
          r_tx_sh <= r_tx_sh << 1;
        end
        if (w_sample) begin
          r_rx_sh <= {r_rx_sh[WORD_LENGTH-2:0], r_mosi_s[1]};
          r_sampled <= 1'b1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_rx_data <= {r_rx_sh[WORD_LENGTH-2:0], r_mosi_s[1]};
            r_rx_valid <= 1'b1;
            r_state <= DONE;
          end
        end
      end
    end
  end
  assign busy = (r_state != IDLE);
  assign miso_oe = busy ? CONNECTED_FROM_SLAVE : DISCONNECTED_FROM_SLAVE;
  assign MISO = r_miso;
  assign tx_ready = ~r_full;
  assign rx_data = r_rx_data;
  assign rx_data_valid = r_rx_valid;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed checks of spi_slave in all four SPI modes, one instance per mode
module tb_spi_slave;
  localparam int H = 5;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] sclk, ssn, mosi, tx_load, miso, miso_oe, tx_ready, rxv, busy;
  logic [7:0] tx_data;
  logic [7:0] rx_data [4];
  logic [7:0] got;
  int vcnt [4] = '{0, 0, 0, 0};
  int n_tests = 0;
  int n_fail = 0;
  int v0;
  always #5 clk = ~clk;
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : u
      spi_slave #(.WORD_LENGTH(8), .SPI_MODE(2'(g))) dut (
        .clk(clk), .rst(rst), .SCLK(sclk[g]), .MOSI(mosi[g]), .SSbar(ssn[g]),
        .MISO(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data), .tx_load(tx_load[g]),
        .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_data_valid(rxv[g]), .busy(busy[g]));
    end
  endgenerate
  always @(negedge clk) for (int k = 0; k < 4; k++) if (rxv[k]) vcnt[k]++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic half(input int k, input bit ld, input logic [7:0] v);
    if (ld) begin
      tx_data = v;
      tx_load[k] = 1'b1;
    end
    @(negedge clk);
    tx_load[k] = 1'b0;
    repeat (H - 1) @(negedge clk);
  endtask
  task automatic load(input int k, input logic [7:0] v);
    tx_data = v;
    tx_load[k] = 1'b1;
    @(negedge clk);
    tx_load[k] = 1'b0;
    @(negedge clk);
  endtask
  task automatic xfer(input int k, input logic [7:0] mo, input int nb, input bit keep,
                      input bit ld, input logic [7:0] lv, output logic [7:0] mi);
    bit cpol, cpha;
    cpol = k[1];
    cpha = k[0];
    mi = '0;
    if (ssn[k]) begin
      ssn[k] = 1'b0;
      repeat (8) @(negedge clk);
    end
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        mosi[k] = mo[7-i];
        half(k, ld && i == 2, lv);
        sclk[k] = ~cpol;
        mi[7-i] = miso[k];
        half(k, 1'b0, 8'h00);
        sclk[k] = cpol;
      end else begin
        sclk[k] = ~cpol;
        mosi[k] = mo[7-i];
        half(k, 1'b0, 8'h00);
        sclk[k] = cpol;
        mi[7-i] = miso[k];
        half(k, ld && i == 2, lv);
      end
    end
    if (!keep) begin
      if (!cpha) half(k, 1'b0, 8'h00);
      ssn[k] = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int bad;
    rst = 1'b1;
    sclk = 4'b1100;
    ssn = 4'hF;
    mosi = '0;
    tx_load = '0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_miso%0d", k), 32'(miso[k]), 0);
      chk($sformatf("rst_oe%0d", k), 32'(miso_oe[k]), 0);
      chk($sformatf("rst_ready%0d", k), 32'(tx_ready[k]), 1);
      chk($sformatf("rst_rx%0d", k), 32'(rx_data[k]), 0);
      chk($sformatf("rst_valid%0d", k), 32'(rxv[k]), 0);
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 0);
    end
    // SCLK activity while deselected
    bad = 0;
    v0 = vcnt[0];
    for (int i = 0; i < 16; i++) begin
      sclk[0] = ~sclk[0];
      mosi[0] = ~mosi[0];
      for (int j = 0; j < H; j++) begin
        @(negedge clk);
        if (miso[0] || miso_oe[0] || rxv[0] || busy[0]) bad++;
      end
    end
    chk("desel_quiet", 32'(bad), 0);
    chk("desel_nvalid", 32'(vcnt[0] - v0), 0);
    // mode 00 basic
    v0 = vcnt[0];
    load(0, 8'hA5);
    chk("m00_ready_low", 32'(tx_ready[0]), 0);
    xfer(0, 8'h3C, 8, 1'b0, 1'b0, 8'h00, got);
    chk("m00_miso", 32'(got), 32'hA5);
    chk("m00_rx", 32'(rx_data[0]), 32'h3C);
    chk("m00_nvalid", 32'(vcnt[0] - v0), 1);
    chk("m00_ready_high", 32'(tx_ready[0]), 1);
    // other modes
    for (int k = 1; k < 4; k++) begin
      v0 = vcnt[k];
      load(k, 8'h81);
      chk($sformatf("m%0d_ready_low", k), 32'(tx_ready[k]), 0);
      xfer(k, 8'h7E, 8, 1'b0, 1'b0, 8'h00, got);
      chk($sformatf("m%0d_miso", k), 32'(got), 32'h81);
      chk($sformatf("m%0d_rx", k), 32'(rx_data[k]), 32'h7E);
      chk($sformatf("m%0d_nvalid", k), 32'(vcnt[k] - v0), 1);
      chk($sformatf("m%0d_ready_high", k), 32'(tx_ready[k]), 1);
    end
    // back-to-back words with a reload during word 1
    v0 = vcnt[0];
    load(0, 8'h5A);
    xfer(0, 8'h11, 8, 1'b1, 1'b1, 8'hC3, got);
    chk("b2b_w1_miso", 32'(got), 32'h5A);
    chk("b2b_w1_rx", 32'(rx_data[0]), 32'h11);
    chk("b2b_w1_nvalid", 32'(vcnt[0] - v0), 1);
    xfer(0, 8'h22, 8, 1'b0, 1'b0, 8'h00, got);
    chk("b2b_w2_miso", 32'(got), 32'hC3);
    chk("b2b_w2_rx", 32'(rx_data[0]), 32'h22);
    chk("b2b_w2_nvalid", 32'(vcnt[0] - v0), 2);
    // back-to-back without reload: second word is zero
    load(0, 8'h96);
    xfer(0, 8'h33, 8, 1'b1, 1'b0, 8'h00, got);
    chk("b2b0_w1_miso", 32'(got), 32'h96);
    xfer(0, 8'h44, 8, 1'b0, 1'b0, 8'h00, got);
    chk("b2b0_w2_miso", 32'(got), 32'h00);
    chk("b2b0_w2_rx", 32'(rx_data[0]), 32'h44);
    // abort after 5 bits
    v0 = vcnt[0];
    load(0, 8'h99);
    xfer(0, 8'hE7, 5, 1'b0, 1'b0, 8'h00, got);
    chk("abort_nvalid", 32'(vcnt[0] - v0), 0);
    chk("abort_rx_kept", 32'(rx_data[0]), 32'h44);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_oe", 32'(miso_oe[0]), 0);
    load(0, 8'h6B);
    xfer(0, 8'h5D, 8, 1'b0, 1'b0, 8'h00, got);
    chk("post_abort_miso", 32'(got), 32'h6B);
    chk("post_abort_rx", 32'(rx_data[0]), 32'h5D);
    chk("post_abort_nvalid", 32'(vcnt[0] - v0), 1);
    // load while not ready is ignored
    load(0, 8'h12);
    load(0, 8'h34);
    chk("ign_ready_low", 32'(tx_ready[0]), 0);
    xfer(0, 8'hF0, 8, 1'b0, 1'b0, 8'h00, got);
    chk("ign_miso", 32'(got), 32'h12);
    chk("ign_rx", 32'(rx_data[0]), 32'hF0);
    chk("ign_ready_high", 32'(tx_ready[0]), 1);
    // reset mid-frame
    load(0, 8'hFF);
    xfer(0, 8'h00, 4, 1'b1, 1'b0, 8'h00, got);
    repeat (H) @(negedge clk);
    chk("mid_busy", 32'(busy[0]), 1);
    chk("mid_oe", 32'(miso_oe[0]), 1);
    chk("mid_miso", 32'(miso[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_miso", 32'(miso[0]), 0);
    chk("rst_mid_oe", 32'(miso_oe[0]), 0);
    chk("rst_mid_ready", 32'(tx_ready[0]), 1);
    chk("rst_mid_rx", 32'(rx_data[0]), 0);
    chk("rst_mid_valid", 32'(rxv[0]), 0);
    chk("rst_mid_busy", 32'(busy[0]), 0);
    rst = 1'b0;
    ssn[0] = 1'b1;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
